// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS = 10;

    // Shortest legal bit period in clock cycles.
    localparam int MIN_DIV = 2;

    // Payload bits between the start and stop bits.
    localparam int DATA_BITS = FRAME_BITS - 2;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with an extra pointer bit so full and empty are unambiguous.
module uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Byte storage; no reset needed because reads are only trusted while non-empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers wrap naturally through the extra wrap bit.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO and a per-frame latched bit period.
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx,
    output logic             busy
);

    tx_state_t        state;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] cnt;
    logic [7:0]       shift;
    logic [2:0]       bit_idx;
    logic             ready_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic             push;
    logic             pop;
    logic             bit_done;
    logic [DIV_W-1:0] eff_div;

    // Bit periods shorter than the minimum are stretched to the minimum.
    assign eff_div  = (clkdiv < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clkdiv;
    assign bit_done = (cnt == period - DIV_W'(1));

    assign in_ready = ready_en && !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && bit_done));
    assign busy     = (state != IDLE) || !fifo_empty;

    uart_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .resetb   (resetb),
        .push     (push),
        .push_data(in_data),
        .pop      (pop),
        .pop_data (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Holds off acceptance until the first clock edge after reset release.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Frame sequencer: latches the bit period at each frame start and shifts data out LSB first.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state   <= IDLE;
            tx      <= 1'b1;
            period  <= '0;
            cnt     <= '0;
            shift   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state  <= START;
                        shift  <= fifo_data;
                        period <= eff_div;
                        cnt    <= '0;
                        tx     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (!fifo_empty) begin
                            state  <= START;
                            shift  <= fifo_data;
                            period <= eff_div;
                            tx     <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx against a queue-based line-level reference model.
module tb_uart_tx;

    localparam int DEPTH = 4;
    localparam int DIV_W = 16;

    logic             clock    = 1'b0;
    logic             resetb   = 1'b0;
    logic [DIV_W-1:0] clkdiv   = 16'd4;
    logic [7:0]       in_data  = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             tx;
    logic             busy;

    int compared   = 0;
    int mismatched = 0;

    // Bytes the source still has to deliver, head is currently offered.
    logic [7:0] src_q[$];
    // Model: bytes accepted but not yet started, and per-cycle future line levels.
    logic [7:0] byte_q[$];
    logic       line_q[$];

    logic exp_tx      = 1'b1;
    logic exp_ready   = 1'b0;
    logic exp_busy    = 1'b0;
    logic last_accept = 1'b0;
    logic m_ready_en  = 1'b0;
    logic check_en    = 1'b0;
    logic gappy       = 1'b0;

    logic [7:0] mb;
    int         mp;
    logic       on_line;
    logic       accept;

    uart_tx #(
        .FIFO_DEPTH(DEPTH),
        .DIV_W     (DIV_W)
    ) dut (
        .clock   (clock),
        .resetb  (resetb),
        .clkdiv  (clkdiv),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    // Reference model: each started byte expands into 10 bits x period cycles of line levels.
    always @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            byte_q.delete();
            line_q.delete();
            m_ready_en  = 1'b0;
            last_accept = 1'b0;
            exp_tx      = 1'b1;
            exp_ready   = 1'b0;
            exp_busy    = 1'b0;
        end else begin
            accept = in_valid && exp_ready;
            if (line_q.size() == 0 && byte_q.size() != 0) begin
                mb = byte_q.pop_front();
                mp = (int'(clkdiv) < 2) ? 2 : int'(clkdiv);
                for (int k = 0; k < 10; k++) begin
                    for (int c = 0; c < mp; c++) begin
                        if (k == 0)      line_q.push_back(1'b0);
                        else if (k == 9) line_q.push_back(1'b1);
                        else             line_q.push_back(mb[k-1]);
                    end
                end
            end
            if (accept) byte_q.push_back(in_data);
            last_accept = accept;
            m_ready_en  = 1'b1;
            if (line_q.size() != 0) begin
                exp_tx  = line_q.pop_front();
                on_line = 1'b1;
            end else begin
                exp_tx  = 1'b1;
                on_line = 1'b0;
            end
            exp_busy  = on_line || (byte_q.size() != 0);
            exp_ready = m_ready_en && (byte_q.size() < DEPTH);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // One call = N cycles: compare outputs at the falling edge, then drive the next offer.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(negedge clock);
            if (check_en) begin
                checkOutput("tx", 32'(tx), 32'(exp_tx));
                checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
                checkOutput("busy", 32'(busy), 32'(exp_busy));
            end
            if (last_accept && src_q.size() != 0) void'(src_q.pop_front());
            in_valid = (src_q.size() != 0) && (!gappy || $urandom_range(0, 2) != 0);
            in_data  = (src_q.size() != 0) ? src_q[0] : 8'($urandom);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_busy) && n < budget) begin
            applyStimulus(1);
            n++;
        end
        if (n >= budget) checkOutput("idle_timeout", 32'(n), 32'(budget - 1));
    endtask

    // Asserts reset right after a falling-edge drive and checks the immediate effect.
    task automatic pulseReset(input int cycles);
        resetb = 1'b0;
        #1;
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        src_q.delete();
        in_valid = 1'b0;
        applyStimulus(cycles);
        resetb = 1'b1;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clock);
        #1;
        check_en = 1'b1;
        checkOutput("por_tx", 32'(tx), 32'd1);
        checkOutput("por_busy", 32'(busy), 32'd0);
        checkOutput("por_ready", 32'(in_ready), 32'd0);
        applyStimulus(2);
        resetb = 1'b1;
        applyStimulus(3);

        $display("[TB] single 0xA5 at clkdiv=4");
        clkdiv = 16'd4;
        src_q.push_back(8'hA5);
        waitIdle(200);
        applyStimulus(3);

        $display("[TB] back-to-back 0x00, 0xFF at clkdiv=4");
        src_q.push_back(8'h00);
        src_q.push_back(8'hFF);
        waitIdle(300);

        $display("[TB] six bytes continuously offered at clkdiv=8");
        clkdiv = 16'd8;
        for (int i = 0; i < 6; i++) src_q.push_back(8'(8'h11 * (i + 1)));
        waitIdle(1000);

        $display("[TB] clkdiv=0 and clkdiv=1");
        clkdiv = 16'd0;
        src_q.push_back(8'h96);
        waitIdle(200);
        clkdiv = 16'd1;
        src_q.push_back(8'h69);
        src_q.push_back(8'h5A);
        waitIdle(200);

        $display("[TB] reset during data bit 3, then 0x3C");
        clkdiv = 16'd4;
        src_q.push_back(8'hC3);
        applyStimulus(20);
        pulseReset(2);
        applyStimulus(2);
        src_q.push_back(8'h3C);
        waitIdle(200);

        $display("[TB] clkdiv 4 -> 6 mid-frame");
        clkdiv = 16'd4;
        src_q.push_back(8'hB7);
        src_q.push_back(8'h4E);
        applyStimulus(12);
        clkdiv = 16'd6;
        waitIdle(400);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 40; it++) begin
            clkdiv = 16'($urandom_range(0, 5));
            gappy  = 1'($urandom_range(0, 1));
            n      = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
            applyStimulus($urandom_range(1, 30));
            if ($urandom_range(0, 3) == 0) clkdiv = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) waitIdle(3000);
        end
        gappy = 1'b0;
        waitIdle(3000);
        applyStimulus(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered bytes (power of two, >= 2).
REQ-002 SHALL have parameter DIV_W, default 16, width of the bit-period divider input.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetb, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port clkdiv, input, DIV_W, clock cycles per serial bit.
REQ-006 SHALL have port in_data, input, 8, byte to transmit.
REQ-007 SHALL have port in_valid, input, 1, in_data is offered.
REQ-008 SHALL have port in_ready, output, 1, byte can be accepted.
REQ-009 SHALL have port tx, output, 1, serial line, idle high; this drives the pad that tbuart samples as ser_rx.
REQ-010 SHALL have port busy, output, 1, high while a frame is on the line or the FIFO is non-empty.

Function
REQ-011 SHALL accept a byte on any rising edge where in_valid and in_ready are both high.
REQ-012 SHALL drive in_ready = not FIFO full; a byte offered while full is not accepted and is not lost by the source.
REQ-013 SHALL allow a push and a pop on the same edge when the FIFO is neither empty nor full, with count unchanged.
REQ-014 SHALL frame each byte as 8N1: one start bit (0), data bits 0..7 LSB first, one stop bit (1).
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
- IDLE->START when the FIFO is non-empty: pops the head byte into the shift register, tx registered low.
- START->DATA after one bit period.
- DATA->DATA after each bit period while bits remain; DATA->STOP after bit 7.
- STOP->START if the FIFO is non-empty at the end of the stop period (back-to-back, no idle gap); otherwise STOP->IDLE.
REQ-016 SHALL make each bit period max(clkdiv,2) cycles, with clkdiv sampled at the START entry and held for the whole frame.
REQ-017 SHALL give one-cycle latency: a byte pushed at edge N into an empty FIFO with FSM in IDLE drives tx low from edge N+1.
REQ-018 SHALL make a frame last exactly 10 bit periods.
REQ-019 SHALL register tx (glitch-free, no combinational path from inputs).
REQ-020 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, using an extra pointer bit to distinguish full from empty.
REQ-021 SHALL deassert busy on the edge at which the FSM enters IDLE with an empty FIFO.

Reset
REQ-022 SHALL, while resetb is low, force tx=1, in_ready=0, busy=0, FSM=IDLE, FIFO empty, counters 0.
REQ-023 SHALL abandon a frame when reset asserts mid-frame, with tx returning high immediately and no partial frame resuming after release.
REQ-024 SHALL drive in_ready=1 on the first rising edge after resetb deasserts.

Structure
REQ-025 SHALL place the FSM state enum, frame length constant (10), and minimum divider constant (2) in shared package uart_pkg.
REQ-026 SHALL implement the byte buffer as sub-module uart_fifo (sync FIFO with push/pop/full/empty), instantiated once.

Verification
REQ-027 SHALL cover clkdiv=4 with byte 0xA5 pushed once: tx = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles (40 cycles total), then busy falls.
REQ-028 SHALL cover clkdiv=4 with 0x00 and 0xFF pushed on consecutive cycles: two frames back-to-back with no idle between the stop bit and the second start bit, 80 cycles total.
REQ-029 SHALL cover 6 bytes offered continuously with FIFO_DEPTH=4 and clkdiv=8: in_ready drops after the FIFO fills, all 6 bytes are transmitted in order, and none are lost or duplicated.
REQ-030 SHALL cover clkdiv=0 and clkdiv=1: the bit period is 2 cycles.
REQ-031 SHALL cover resetb pulsed low during DATA bit 3: tx goes to 1 at once, busy=0; after release a new 0x3C frame is correct.
REQ-032 SHALL cover clkdiv changed from 4 to 6 mid-frame: the current frame keeps 4-cycle bits and the next frame uses 6-cycle bits.
